// File: rtl/regfile_pkg.sv
// Shared types for the register-read/issue stage: register codes, operand data,
// the writeback bus and the execute-side holding register.
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 4;
  localparam int DATA_W   = 64;
  localparam int STALL_W  = 32;

  typedef logic [0:REG_W-1]    reg_code_t;
  typedef logic [0:DATA_W-1]   data_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  typedef struct packed {
    logic      valid;
    reg_code_t dest;
    reg_code_t dest_special;
    logic      special_valid;
    data_t     data;
    data_t     data_special;
  } wb_bus_t;

  typedef struct packed {
    data_t     rip;
    data_t     opnd1;
    data_t     opnd2;
    reg_code_t dest;
    reg_code_t dest_special;
    logic      dest_valid;
    logic      dest_special_valid;
  } ex_entry_t;

  // One-hot mask for a register code, or all-zero when the code is unused.
  function automatic reg_mask_t code_mask(reg_code_t code, logic en);
    reg_mask_t m;
    m = '0;
    if (en) m[code] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_read_scoreboard_if.sv
// Decode, execute and writeback signals of the issue stage. The stage itself
// uses the slave view; the surrounding pipeline (or a bench) uses master.
interface reg_read_scoreboard_if;
  import regfile_pkg::*;

  logic      decValidIn;
  logic      decReadyOut;
  data_t     decRipIn;
  reg_code_t src1In;
  reg_code_t src2In;
  logic      src1ValidIn;
  logic      src2ValidIn;
  reg_code_t destIn;
  reg_code_t destSpecialIn;
  logic      destValidIn;
  logic      destSpecialValidIn;

  logic      exValidOut;
  logic      exReadyIn;
  data_t     exRipOut;
  data_t     opnd1Out;
  data_t     opnd2Out;
  reg_code_t destOut;
  reg_code_t destSpecialOut;
  logic      destValidOut;
  logic      destSpecialValidOut;

  logic      wbValidIn;
  reg_code_t wbDestIn;
  reg_code_t wbDestSpecialIn;
  logic      wbDestSpecialValidIn;
  data_t     wbDataIn;
  data_t     wbDataSpecialIn;

  modport master (
    output decValidIn, decRipIn, src1In, src2In, src1ValidIn, src2ValidIn,
           destIn, destSpecialIn, destValidIn, destSpecialValidIn,
           exReadyIn,
           wbValidIn, wbDestIn, wbDestSpecialIn, wbDestSpecialValidIn,
           wbDataIn, wbDataSpecialIn,
    input  decReadyOut,
           exValidOut, exRipOut, opnd1Out, opnd2Out, destOut, destSpecialOut,
           destValidOut, destSpecialValidOut
  );

  modport slave (
    input  decValidIn, decRipIn, src1In, src2In, src1ValidIn, src2ValidIn,
           destIn, destSpecialIn, destValidIn, destSpecialValidIn,
           exReadyIn,
           wbValidIn, wbDestIn, wbDestSpecialIn, wbDestSpecialValidIn,
           wbDataIn, wbDataSpecialIn,
    output decReadyOut,
           exValidOut, exRipOut, opnd1Out, opnd2Out, destOut, destSpecialOut,
           destValidOut, destSpecialValidOut
  );

endinterface

// File: rtl/scoreboard_bitmap.sv
// Register in-use bitmap: issue sets bits, writeback clears them, and a set
// on the same register in the same cycle wins because it marks a new producer.
module scoreboard_bitmap
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_valid_i,
  input  reg_code_t set_code_i,
  input  logic      set_special_valid_i,
  input  reg_code_t set_special_code_i,
  input  logic      clr_valid_i,
  input  reg_code_t clr_code_i,
  input  logic      clr_special_valid_i,
  input  reg_code_t clr_special_code_i,
  output reg_mask_t busy_o,
  output reg_mask_t eff_busy_o
);

  reg_mask_t busy_q;
  reg_mask_t busy_d;
  reg_mask_t set_mask;
  reg_mask_t clr_mask;
  reg_mask_t eff_busy;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    set_mask = code_mask(set_code_i, set_valid_i)
             | code_mask(set_special_code_i, set_special_valid_i);
    clr_mask = code_mask(clr_code_i, clr_valid_i)
             | code_mask(clr_special_code_i, clr_special_valid_i);
    eff_busy = busy_q & ~clr_mask;
    busy_d   = eff_busy | set_mask;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign eff_busy_o = eff_busy;

endmodule

// File: rtl/reg_read_scoreboard.sv
// Register-read/issue stage: owns the architectural register file and the
// in-use scoreboard, stalls on RAW/WAW hazards and reads operands with WB bypass.
module reg_read_scoreboard
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  reg_read_scoreboard_if.slave bus_if,
  output reg_mask_t            regInUseBitMapOut,
  output logic [STALL_W-1:0]   stallCountOut
);

  wb_bus_t            wb;
  data_t              regfile_q [NUM_REGS];
  reg_mask_t          busy;
  reg_mask_t          eff_busy;
  ex_entry_t          ex_q;
  ex_entry_t          ex_d;
  logic               ex_valid_q;
  logic               ex_valid_d;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;
  logic               hazard;
  logic               dec_ready;
  logic               issue;
  data_t              opnd1;
  data_t              opnd2;

  assign wb = '{
    valid:         bus_if.wbValidIn,
    dest:          bus_if.wbDestIn,
    dest_special:  bus_if.wbDestSpecialIn,
    special_valid: bus_if.wbValidIn & bus_if.wbDestSpecialValidIn,
    data:          bus_if.wbDataIn,
    data_special:  bus_if.wbDataSpecialIn
  };

  // Writeback data is forwarded so a consumer can issue in its producer's WB cycle.
  function automatic data_t read_opnd(reg_code_t src, logic src_valid,
                                      wb_bus_t wbb, data_t rf_val);
    if (!src_valid)                                     return '0;
    else if (wbb.valid && src == wbb.dest)              return wbb.data;
    else if (wbb.special_valid && src == wbb.dest_special) return wbb.data_special;
    else                                                return rf_val;
  endfunction

  assign opnd1 = read_opnd(bus_if.src1In, bus_if.src1ValidIn, wb, regfile_q[bus_if.src1In]);
  assign opnd2 = read_opnd(bus_if.src2In, bus_if.src2ValidIn, wb, regfile_q[bus_if.src2In]);

  scoreboard_bitmap u_bitmap (
    .clk                 (clk),
    .reset               (reset),
    .set_valid_i         (issue & bus_if.destValidIn),
    .set_code_i          (bus_if.destIn),
    .set_special_valid_i (issue & bus_if.destSpecialValidIn),
    .set_special_code_i  (bus_if.destSpecialIn),
    .clr_valid_i         (wb.valid),
    .clr_code_i          (wb.dest),
    .clr_special_valid_i (wb.special_valid),
    .clr_special_code_i  (wb.dest_special),
    .busy_o              (busy),
    .eff_busy_o          (eff_busy)
  );

  always_comb begin
    hazard = (bus_if.src1ValidIn        & eff_busy[bus_if.src1In])
           | (bus_if.src2ValidIn        & eff_busy[bus_if.src2In])
           | (bus_if.destValidIn        & eff_busy[bus_if.destIn])
           | (bus_if.destSpecialValidIn & eff_busy[bus_if.destSpecialIn]);
    dec_ready = ~hazard & (~ex_valid_q | bus_if.exReadyIn);
    issue     = bus_if.decValidIn & dec_ready;
  end

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_d = '{
        rip:                bus_if.decRipIn,
        opnd1:              opnd1,
        opnd2:              opnd2,
        dest:               bus_if.destIn,
        dest_special:       bus_if.destSpecialIn,
        dest_valid:         bus_if.destValidIn,
        dest_special_valid: bus_if.destSpecialValidIn
      };
    end else if (ex_valid_q && bus_if.exReadyIn) begin
      ex_valid_d = 1'b0;
    end

    stall_d = stall_q;
    if (bus_if.decValidIn && !dec_ready && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      stall_q    <= stall_d;
    end
  end

  // NOTE: the register file is architecturally visible and must read zero after reset,
  // so it is built from resettable flops rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regfile_q[i] <= '0;
    end else if (wb.valid) begin
      if (wb.special_valid) regfile_q[wb.dest_special] <= wb.data_special;
      regfile_q[wb.dest] <= wb.data;  // placed last so the main result wins on equal codes
    end
  end

  assign bus_if.decReadyOut         = dec_ready;
  assign bus_if.exValidOut          = ex_valid_q;
  assign bus_if.exRipOut            = ex_q.rip;
  assign bus_if.opnd1Out            = ex_q.opnd1;
  assign bus_if.opnd2Out            = ex_q.opnd2;
  assign bus_if.destOut             = ex_q.dest;
  assign bus_if.destSpecialOut      = ex_q.dest_special;
  assign bus_if.destValidOut        = ex_q.dest_valid;
  assign bus_if.destSpecialValidOut = ex_q.dest_special_valid;
  assign regInUseBitMapOut          = busy;
  assign stallCountOut              = stall_q;

endmodule

// File: doc/reg_read_scoreboard.md
Name: reg_read_scoreboard

Overview:
Register-read/issue stage; the issuing end of the register-in-use protocol that writeback retires. It owns the 16x64 architectural register file and the 16-bit in-use scoreboard. It accepts decoded instructions, stalls on RAW/WAW hazards, reads operands with writeback bypass, sets busy bits on issue, and clears them/writes data on writeback. It sits between decode and execute, and writeback feeds it back.

Parameters:
NUM_REGS, 16, architectural register count
REG_W, 4, register code width (bit order [0:3])
DATA_W, 64, register/operand width (bit order [0:63])
STALL_W, 32, stall counter width

Ports:
clk  in  1  clock; all state on posedge
reset  in  1  synchronous, active-high
decValidIn  in  1  decode has an instruction
decReadyOut  out  1  stage can accept this cycle
decRipIn  in  64  instruction RIP
src1In / src2In  in  4 each  source register codes
src1ValidIn / src2ValidIn  in  1 each  source used
destIn / destSpecialIn  in  4 each  destination codes
destValidIn / destSpecialValidIn  in  1 each  destination written
exValidOut  out  1  instruction held for execute
exReadyIn  in  1  execute accepts
exRipOut  out  64  registered RIP
opnd1Out / opnd2Out  out  64 each  registered operand values
destOut / destSpecialOut  out  4 each  registered dest codes
destValidOut / destSpecialValidOut  out  1 each  registered dest valids
wbValidIn  in  1  writeback commit this cycle
wbDestIn / wbDestSpecialIn  in  4 each  writeback dest codes
wbDestSpecialValidIn  in  1  special dest valid
wbDataIn / wbDataSpecialIn  in  64 each  writeback results
regInUseBitMapOut  out  16  current scoreboard (bit n = reg n busy)
stallCountOut  out  32  cycles stalled by hazard/backpressure

Behaviour:
- Reset: regFile all 0; scoreboard 0; exValidOut 0; all ex* outputs 0; stallCountOut 0. Reset mid-operation discards the held instruction and all busy bits. The rest of the pipeline resets in the same cycle.
- Writeback (wbValidIn=1), at posedge: regFile[wbDestIn]<=wbDataIn, busy[wbDestIn] cleared. If wbDestSpecialValidIn, also regFile[wbDestSpecialIn]<=wbDataSpecialIn, busy cleared. If both codes are equal, wbDataIn wins.
- wbClr = cleared set this cycle. effBusy = busy & ~wbClr (combinational).
- Operand read is combinational and bypasses writeback. If src == wbDestIn and wbValidIn, use wbDataIn. Else if src == wbDestSpecialIn with valid, use wbDataSpecialIn. Else use regFile. If srcValid=0, the operand is 0.
- hazard = any valid src or valid dest/destSpecial whose effBusy bit is set. This covers RAW and WAW.
- decReadyOut = ~hazard & (~exValidOut | exReadyIn). It is computed from the field values and does not depend on decValidIn.
- issue = decValidIn & decReadyOut. On issue, at posedge:
  - load all ex* outputs; exValidOut<=1
  - set busy[destIn] if destValidIn, and busy[destSpecialIn] if destSpecialValidIn
- Issue set overrides a same-cycle writeback clear on the same register (new producer).
- If exValidOut & exReadyIn & ~issue: exValidOut<=0; data outputs keep their values.
- While exValidOut & ~exReadyIn: all ex* outputs hold stable.
- Latency: decode→execute 1 cycle. A dependent instruction issues in the same cycle as its producer's writeback (bypass).
- Throughput: one instruction per cycle when there is no hazard.
- stallCountOut increments when decValidIn & ~decReadyOut. It saturates at all-ones.
- dest == destSpecial with both valid: a single busy bit, no error.

Decomposition:
- Package regfile_pkg: typedef reg_code_t (logic [0:3]), data_t (logic [0:63]), NUM_REGS constant, wb_bus_t struct (valid, dest, destSpecial, specialValid, data, dataSpecial).
- Sub-module scoreboard_bitmap:
  - holds the 16 busy bits
  - set port: two codes + valids; clear port: two codes + valids; set wins
  - outputs current and effective (post-clear) bitmaps
- Register file, bypass, and handshake stay in the top.

Test Plan:
- Reset, then issue src1=R1, dest=R2 with no writeback → next cycle exValidOut=1, opnd1Out=0, regInUseBitMapOut=16'h0004.
- RAW: R2 busy, issue src1=R2 → decReadyOut=0 and stallCountOut increments. Then wbValidIn with wbDestIn=R2, wbDataIn=64'hDEAD_BEEF in the same cycle as decode → issue that cycle, opnd1Out=64'hDEAD_BEEF, busy[2]=0.
- WAW: R3 busy, new dest=R3 → stall until writeback of R3. Issue in the writeback cycle leaves busy[3]=1 (set wins).
- Backpressure: exReadyIn=0 with exValidOut=1 → decReadyOut=0, outputs stable 3 cycles. exReadyIn=1 → held instruction drains and the next instruction loads the same cycle.
- Dual writeback wbDestIn=wbDestSpecialIn=R5, data A/B → regFile[5]=A, busy[5]=0.
- Sync reset asserted while exValidOut=1 and busy=16'h00F0 → next cycle exValidOut=0, regInUseBitMapOut=0, stallCountOut=0.
